// File: rtl/xnor_gate.sv
// Bitwise 2-input XNOR with an optional registered compare stage.
// F_o is purely combinational; the registered outputs capture the result,
// an all-bits-equal flag and a matching-bit count whenever valid_i is high.
module xnor_gate #(
    parameter int unsigned WIDTH = 1,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] F_o,
    output logic [WIDTH-1:0] F_r_o,
    output logic             eq_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] f_d;
    logic [WIDTH-1:0] f_q;
    logic             eq_d;
    logic             eq_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;

    // Combinational XNOR; X/Z on an input bit propagates to that output bit.
    assign f_d = ~(A_i ^ B_i);
    assign F_o = f_d;

    // Equality flag and popcount of matching bits for the capture stage.
    always_comb begin
        eq_d  = &f_d;
        cnt_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d = cnt_d + CNT_W'(f_d[i]);
        end
    end

    // Capture stage: data held when valid_i is low, valid_o follows valid_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_q     <= '0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                f_q   <= f_d;
                eq_q  <= eq_d;
                cnt_q <= cnt_d;
            end
        end
    end

    assign F_r_o       = f_q;
    assign eq_o        = eq_q;
    assign match_cnt_o = cnt_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_xnor_gate.sv
// Scoreboarded bench for xnor_gate: an 8-bit instance on a running clock and
// a 1-bit instance with its clock held idle for the combinational truth table.
module tb_xnor_gate;

    typedef struct {
        logic [7:0] f;
        logic       eq;
        logic [3:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       vld;
    logic [7:0] f;
    logic [7:0] f_r;
    logic       eq;
    logic [3:0] cnt;
    logic       vld_o;

    logic       clk1;
    logic       rst1_n;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       vld1;
    logic [0:0] f1;
    logic [0:0] f1_r;
    logic       eq1;
    logic [0:0] cnt1;
    logic       vld1_o;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 0;

    xnor_gate #(.WIDTH(8)) u_dut8 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .A_i        (a),
        .B_i        (b),
        .valid_i    (vld),
        .F_o        (f),
        .F_r_o      (f_r),
        .eq_o       (eq),
        .match_cnt_o(cnt),
        .valid_o    (vld_o)
    );

    xnor_gate #(.WIDTH(1)) u_dut1 (
        .clk_i      (clk1),
        .rst_ni     (rst1_n),
        .A_i        (a1),
        .B_i        (b1),
        .valid_i    (vld1),
        .F_o        (f1),
        .F_r_o      (f1_r),
        .eq_o       (eq1),
        .match_cnt_o(cnt1),
        .valid_o    (vld1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one valid vector and record its hand-computed result.
    task automatic send(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] ef, input logic eeq, input logic [3:0] ecnt);
        exp_t e;
        a   = va;
        b   = vb;
        vld = 1'b1;
        e.f   = ef;
        e.eq  = eeq;
        e.cnt = ecnt;
        q.push_back(e);
        #1 check("F_o comb", {56'd0, f}, {56'd0, ef});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        clk1   = 1'b0;
        rst1_n = 1'b1;
        a1     = 1'b0;
        b1     = 1'b0;
        vld1   = 1'b0;
        rst_n  = 1'b0;
        vld    = 1'b0;
        a      = 8'h00;
        b      = 8'h00;

        // Monitor: compare every presented result against the scoreboard head.
        fork
            begin
                exp_t e;
                while (!done) begin
                    @(negedge clk);
                    if (vld_o === 1'b1) begin
                        if (q.size() == 0) begin
                            check("unexpected valid_o", 64'd1, 64'd0);
                        end else begin
                            e = q.pop_front();
                            check("F_r_o", {56'd0, f_r}, {56'd0, e.f});
                            check("eq_o", {63'd0, eq}, {63'd0, e.eq});
                            check("match_cnt_o", {60'd0, cnt}, {60'd0, e.cnt});
                        end
                    end
                end
            end
        join_none

        #2;
        check("reset F_r_o", {56'd0, f_r}, 64'd0);
        check("reset eq_o", {63'd0, eq}, 64'd0);
        check("reset match_cnt_o", {60'd0, cnt}, 64'd0);
        check("reset valid_o", {63'd0, vld_o}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands, then a valid_i=0 edge must drop valid_o and hold data.
        @(negedge clk); send(8'hA5, 8'hA5, 8'hFF, 1'b1, 4'd8);
        @(negedge clk); vld = 1'b0; a = 8'h00; b = 8'hFF;
        @(negedge clk);
        #1;
        check("valid_o low after idle", {63'd0, vld_o}, 64'd0);
        check("held F_r_o", {56'd0, f_r}, 64'hFF);
        check("held eq_o", {63'd0, eq}, 64'd1);
        check("held match_cnt_o", {60'd0, cnt}, 64'd8);

        @(negedge clk); send(8'hF0, 8'h0F, 8'h00, 1'b0, 4'd0);
        @(negedge clk); send(8'hC3, 8'hC0, 8'hFC, 1'b0, 4'd6);
        @(negedge clk); vld = 1'b0;
        drain();

        // Back-to-back stream: results must come out in order on consecutive cycles.
        @(negedge clk); send(8'h00, 8'h00, 8'hFF, 1'b1, 4'd8);
        @(negedge clk); send(8'h5A, 8'h3C, 8'h99, 1'b0, 4'd4);
        @(negedge clk); send(8'hFF, 8'hFF, 8'hFF, 1'b1, 4'd8);
        @(negedge clk); send(8'h80, 8'h00, 8'h7F, 1'b0, 4'd7);
        #1 check("valid_o streaming", {63'd0, vld_o}, 64'd1);
        @(negedge clk); vld = 1'b0;
        drain();

        // Reset between edges with a capture pending: outputs clear at once.
        @(negedge clk);
        a = 8'h12; b = 8'h34; vld = 1'b1;
        @(posedge clk);
        #1 check("pre-reset valid_o", {63'd0, vld_o}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async F_r_o", {56'd0, f_r}, 64'd0);
        check("async eq_o", {63'd0, eq}, 64'd0);
        check("async match_cnt_o", {60'd0, cnt}, 64'd0);
        check("async valid_o", {63'd0, vld_o}, 64'd0);
        a = 8'hFF; b = 8'h00;
        #1 check("F_o in reset", {56'd0, f}, 64'h00);
        a = 8'h3C; b = 8'h3C;
        #1 check("F_o in reset 2", {56'd0, f}, 64'hFF);
        @(posedge clk);
        #1;
        check("held reset F_r_o", {56'd0, f_r}, 64'd0);
        check("held reset valid_o", {63'd0, vld_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h33, 8'h33, 8'hFF, 1'b1, 4'd8);
        @(negedge clk); vld = 1'b0;
        drain();

        // 1-bit truth table with the clock idle.
        a1 = 1'b0; b1 = 1'b0; #2 check("w1 00", {63'd0, f1}, 64'd1); #3;
        a1 = 1'b1; b1 = 1'b0; #2 check("w1 10", {63'd0, f1}, 64'd0); #3;
        a1 = 1'b0; b1 = 1'b1; #2 check("w1 01", {63'd0, f1}, 64'd0); #3;
        a1 = 1'b1; b1 = 1'b1; #2 check("w1 11", {63'd0, f1}, 64'd1); #3;
        check("w1 valid_o idle", {63'd0, vld1_o}, 64'd0);

        done = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
